// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: one row driven low at a time, whole-frame debounce,
// debounced key levels plus a one-cycle pulse for each newly committed press.
module keypad_scan #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned DEBOUNCE_CNT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  col_in,
    output logic [3:0]  row_out,
    output logic [15:0] key_state,
    output logic [15:0] key_pulse
);

    localparam int unsigned DivW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CntW = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [DivW-1:0] DivMax    = DivW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0] CntCommit = CntW'(DEBOUNCE_CNT - 1);
    localparam logic [CntW-1:0] CntSat    = CntW'(DEBOUNCE_CNT);

    logic [3:0]      col_s1_q;
    logic [3:0]      col_s_q;
    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]      row_idx_q, row_idx_d;
    logic [3:0]      row_out_q, row_out_d;
    logic [15:0]     raw_frame_q, raw_frame_d;
    logic [15:0]     last_frame_q, last_frame_d;
    logic [CntW-1:0] stable_cnt_q, stable_cnt_d;
    logic [15:0]     key_state_q, key_state_d;
    logic [15:0]     key_pulse_q, key_pulse_d;

    logic            tick;
    logic            frame_end;
    logic [15:0]     frame;

    assign tick      = (div_cnt_q == DivMax);
    assign frame_end = tick && (row_idx_q == 2'd3);
    // Row 3 is sampled on the same edge the frame is judged, so splice it in live.
    assign frame     = {~col_s_q, raw_frame_q[11:0]};

    // Scan divider, row sequencing and raw frame capture.
    always_comb begin
        div_cnt_d   = div_cnt_q + 1'b1;
        row_idx_d   = row_idx_q;
        row_out_d   = row_out_q;
        raw_frame_d = raw_frame_q;
        if (tick) begin
            div_cnt_d                            = '0;
            row_idx_d                            = row_idx_q + 2'd1;
            row_out_d                            = ~(4'b0001 << row_idx_d);
            raw_frame_d[{row_idx_q, 2'b00} +: 4] = ~col_s_q;
        end
    end

    // Frame debounce and commit.
    always_comb begin
        last_frame_d = last_frame_q;
        stable_cnt_d = stable_cnt_q;
        key_state_d  = key_state_q;
        key_pulse_d  = '0;
        if (frame_end) begin
            if (frame != last_frame_q) begin
                last_frame_d = frame;
                stable_cnt_d = CntW'(1);
            end else if (stable_cnt_q < CntCommit) begin
                stable_cnt_d = stable_cnt_q + 1'b1;
            end else if (stable_cnt_q == CntCommit) begin
                stable_cnt_d = CntSat;
                key_state_d  = frame;
                key_pulse_d  = frame & ~key_state_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_s1_q     <= 4'b1111;
            col_s_q      <= 4'b1111;
            div_cnt_q    <= '0;
            row_idx_q    <= 2'd0;
            row_out_q    <= 4'b1110;
            raw_frame_q  <= '0;
            last_frame_q <= '0;
            stable_cnt_q <= '0;
            key_state_q  <= '0;
            key_pulse_q  <= '0;
        end else begin
            col_s1_q     <= col_in;
            col_s_q      <= col_s1_q;
            div_cnt_q    <= div_cnt_d;
            row_idx_q    <= row_idx_d;
            row_out_q    <= row_out_d;
            raw_frame_q  <= raw_frame_d;
            last_frame_q <= last_frame_d;
            stable_cnt_q <= stable_cnt_d;
            key_state_q  <= key_state_d;
            key_pulse_q  <= key_pulse_d;
        end
    end

    assign row_out   = row_out_q;
    assign key_state = key_state_q;
    assign key_pulse = key_pulse_q;

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scans a 4x4 matrix keypad by driving one row low at a time and sampling the four column inputs.
- Debounces whole-keypad frames and emits a one-cycle `key_pulse` bit for each newly pressed key.
- Sits between the keypad pins and the key latch register, which sets a sticky bit on each `key_pulse` rising edge.
- Also exports the debounced key level vector.

Parameters:
- SCAN_DIV, 50000, clk cycles each row is driven before its columns are sampled. Must be at least 4.
- DEBOUNCE_CNT, 4, number of consecutive identical frames required before a frame is committed. Must be at least 2.

Ports:
- clk  input  1  system clock; the only clock. One clock domain; reset is asynchronous and active-high.
- rst  input  1  asynchronous, active-high reset.
- col_in  input  4  raw keypad column pins, active-low, pulled up; asynchronous to clk.
- row_out  output  4  keypad row drive, active-low, exactly one row low at a time.
- key_state  output  16  debounced level per key; bit index = row*4+col; 1 = pressed.
- key_pulse  output  16  one-clk pulse per key on a committed press.

Behaviour:
- Reset (async assert, removed synchronously by the system):
  - row_idx=0, so row_out=4'b1110.
  - div_cnt=0; raw_frame, last_frame, stable_cnt, key_state, key_pulse all 0.
  - Column synchronizer flops are set to 4'b1111.
  - Reset asserted mid-scan aborts the frame in progress; no pulse is generated.
- Column sync: col_in passes through a 2-flop synchronizer giving col_s. Samples use col_s.
- Divider: div_cnt counts 0..SCAN_DIV-1 and wraps. `tick` = (div_cnt==SCAN_DIV-1).
- On each tick:
  - raw_frame[row_idx*4 +: 4] <= ~col_s.
  - row_idx <= row_idx+1 mod 4, wrapping 3 to 0.
  - row_out = ~(4'b0001 << row_idx), registered and updated together with row_idx.
  - Row timing: each row is driven for SCAN_DIV cycles. Its sample is taken on the last cycle of that slot, leaving time for settling and sync.
- Frame end: a tick with row_idx==3. `frame` = raw_frame with the row-3 nibble replaced by the current ~col_s. Frame period = 4*SCAN_DIV cycles.
- Debounce, evaluated at frame end:
  - frame != last_frame: last_frame <= frame, stable_cnt <= 1.
  - frame == last_frame and stable_cnt < DEBOUNCE_CNT-1: stable_cnt increments.
  - frame == last_frame and stable_cnt == DEBOUNCE_CNT-1: commit. stable_cnt <= DEBOUNCE_CNT, which saturates at DEBOUNCE_CNT.
  - Commit effect: key_state <= frame and key_pulse <= frame & ~key_state, both in the cycle after the frame-end tick.
  - Net rule: a frame commits once seen in DEBOUNCE_CNT consecutive frames. Once saturated, it never re-commits, so no further pulses while a key is held.
- key_pulse:
  - Registered; high for exactly one clk.
  - 0 in every cycle that is not a commit cycle.
  - Releases (1 to 0 in key_state) never produce a pulse.
  - Multiple keys newly pressed in the same committed frame pulse in the same cycle.
- Latency: a press stable before a frame starts shows on key_pulse 1 clk after the frame-end tick of the DEBOUNCE_CNT-th identical frame.
- Bounce: any frame differing from last_frame restarts the count. A key that alternates every frame never commits.
- Ghosting/masking on 3+ key patterns is not resolved; the raw frame is passed through debounce unchanged.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_CNT=3, giving a 16-cycle frame. The keypad model pulls col_in[c] low while row_out[r]==0 and key r*4+c is held.
- Reset then idle: row_out sequence 1110, 1101, 1011, 0111, each held 4 clk, repeating. key_state=0 and key_pulse=0 throughout.
- Hold key 5 (row 1, col 1) from a frame start:
  - key_pulse==16'h0020 for exactly 1 clk, 1 clk after the 3rd frame-end tick.
  - key_state==16'h0020 from then on.
  - No second pulse over 10 further frames.
- Bounce: toggle key 5 every frame for 8 frames. key_pulse stays 0 and key_state stays 0.
- Press keys 0 and 15 together: one key_pulse==16'h8001 for 1 clk. Then add key 3 while both are held: next pulse==16'h0008 only.
- Release all keys from key_state==16'h8009: key_state goes to 0 after 3 stable frames; key_pulse stays 0.
- Assert rst mid-frame while key 5 is held:
  - Immediately: key_state=0, key_pulse=0, row_out=1110.
  - After rst release, a key_pulse==16'h0020 is produced again after 3 frames.
